// File: rtl/fsk_frame_modulator.sv
// -----------------------------------------------------------------------------
// fsk_frame_modulator
//   Binary-FSK transmitter for the ultrasonic modem. Each accepted word is
//   framed as start(0) + DATA_W data bits (LSB first) + stop(1). Every bit is
//   sent for BIT_CYCLES clocks as a square-wave tone whose half-period is HALF0
//   (space, bit 0) or HALF1 (mark, bit 1). Tone changes are phase-continuous:
//   the half-period in progress always completes before the new tone applies.
//
// Ports
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_enable      transmitter enable; low aborts any frame and silences output
//   i_s_data      word to send (sampled only on the transfer edge)
//   i_s_valid     i_s_data valid
//   o_s_ready     block accepts i_s_data this cycle (combinational)
//   o_fsk_out     FSK square-wave output (registered)
//   o_busy        frame in progress (registered, state != IDLE)
//   o_bit_strobe  one-cycle pulse at every bit boundary inside a frame
//   o_dbg_state   current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Handshake: a transfer happens on any rising clock edge where i_s_valid and
// o_s_ready are both high; o_s_ready never depends on i_s_valid.
// -----------------------------------------------------------------------------
module fsk_frame_modulator #(
  parameter int DATA_W     = 8,
  parameter int HALF0      = 84,
  parameter int HALF1      = 78,
  parameter int BIT_CYCLES = 5000,
  parameter int HALF_W     = 16,
  parameter int BIT_W      = 16,
  parameter int IDLE_TONE  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  output logic              o_fsk_out,
  output logic              o_busy,
  output logic              o_bit_strobe,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int              IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BIT_CYCLES - 1);
  localparam logic [HALF_W-1:0] RELOAD0   = HALF_W'(HALF0 - 1);
  localparam logic [HALF_W-1:0] RELOAD1   = HALF_W'(HALF1 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic            TONE_IDLE = (IDLE_TONE != 0);

  state_t              r_state;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_shift;
  logic [HALF_W-1:0]   r_half_cnt;
  logic                r_fsk;
  logic                r_busy;
  logic                r_strobe;

  logic                w_bit_end;
  logic                w_ready;
  logic                w_xfer;
  logic                w_bit;
  logic                w_carrier_on;
  logic [HALF_W-1:0]   w_reload;
  state_t              w_state_nxt;

  assign w_bit_end    = (r_bit_cnt == BIT_LAST);
  assign w_ready      = i_enable & i_rst_n &
                        ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_end));
  assign w_xfer       = w_ready & i_s_valid;
  assign w_carrier_on = (r_state != ST_IDLE) | TONE_IDLE;
  assign w_reload     = w_bit ? RELOAD1 : RELOAD0;

  // Bit currently being sent; selects the half-period loaded at the next toggle.
  always_comb begin
    w_bit = 1'b0;
    case (r_state)
      ST_START: w_bit = 1'b0;
      ST_DATA:  w_bit = r_shift[0];
      ST_STOP:  w_bit = 1'b1;
      default:  w_bit = TONE_IDLE;
    endcase
  end

  // Next state with enable assumed high; the abort path overrides it.
  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) begin
      w_state_nxt = ST_START;
    end else begin
      case (r_state)
        ST_START: if (w_bit_end) w_state_nxt = ST_DATA;
        ST_DATA:  if (w_bit_end && (r_idx == IDX_LAST)) w_state_nxt = ST_STOP;
        ST_STOP:  if (w_bit_end) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_half_cnt <= '0;
      r_fsk      <= 1'b0;
      r_busy     <= 1'b0;
      r_strobe   <= 1'b0;
    end else if (!i_enable) begin
      // Abort: the frame is dropped and the carrier goes silent.
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_idx      <= '0;
      r_half_cnt <= '0;
      r_fsk      <= 1'b0;
      r_busy     <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);

      // Bit timing and payload shifting.
      if (w_xfer) begin
        r_shift   <= i_s_data;
        r_bit_cnt <= '0;
        r_idx     <= '0;
        // A back-to-back transfer still marks the STOP->START boundary.
        r_strobe  <= (r_state == ST_STOP);
      end else if (r_state != ST_IDLE) begin
        r_strobe <= w_bit_end;
        if (w_bit_end) begin
          r_bit_cnt <= '0;
          if (r_state == ST_DATA) begin
            r_shift <= r_shift >> 1;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else begin
        r_strobe  <= 1'b0;
        r_bit_cnt <= '0;
      end

      // Tone generator. The countdown is never restarted at bit boundaries,
      // so every high/low interval is a whole HALF0 or HALF1.
      if (w_xfer && !w_carrier_on) begin
        r_half_cnt <= RELOAD0;
        r_fsk      <= 1'b0;
      end else if ((w_state_nxt == ST_IDLE) && !TONE_IDLE) begin
        r_half_cnt <= '0;
        r_fsk      <= 1'b0;
      end else if (r_half_cnt == '0) begin
        r_fsk      <= ~r_fsk;
        r_half_cnt <= w_reload;
      end else begin
        r_half_cnt <= r_half_cnt - 1'b1;
      end
    end
  end

  assign o_s_ready    = w_ready;
  assign o_fsk_out    = r_fsk;
  assign o_busy       = r_busy;
  assign o_bit_strobe = r_strobe;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fsk_frame_modulator.sv
// -----------------------------------------------------------------------------
// tb_fsk_frame_modulator
//   Directed bench for fsk_frame_modulator with DATA_W=8, HALF0=4, HALF1=3,
//   BIT_CYCLES=24. u_dut runs with the carrier off in idle, u_dut_mk with the
//   mark tone in idle. Frames are checked against hand-written 10-bit frame
//   images {stop, data[7:0], start}.
// -----------------------------------------------------------------------------
module tb_fsk_frame_modulator;

  localparam int BITC  = 24;
  localparam int FRAME = 10 * BITC;
  localparam int CAPN  = 600;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT (idle carrier off) ----------------
  logic       enable;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       fsk;
  logic       busy;
  logic       stb;
  logic [1:0] st;

  fsk_frame_modulator #(
    .DATA_W(8), .HALF0(4), .HALF1(3), .BIT_CYCLES(BITC),
    .HALF_W(16), .BIT_W(16), .IDLE_TONE(0)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .o_fsk_out(fsk), .o_busy(busy), .o_bit_strobe(stb), .o_dbg_state(st)
  );

  // ---------------- DUT (idle mark tone) ----------------
  logic       en1;
  logic [7:0] data1;
  logic       valid1;
  logic       rdy1;
  logic       fsk1;
  logic       busy1;
  logic       stb1;
  logic [1:0] st1;

  fsk_frame_modulator #(
    .DATA_W(8), .HALF0(4), .HALF1(3), .BIT_CYCLES(BITC),
    .HALF_W(16), .BIT_W(16), .IDLE_TONE(1)
  ) u_dut_mk (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en1),
    .i_s_data(data1), .i_s_valid(valid1), .o_s_ready(rdy1),
    .o_fsk_out(fsk1), .o_busy(busy1), .o_bit_strobe(stb1), .o_dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic exp_q[$];          // expected bit per bit slot, in transmission order
  logic cap_fsk [CAPN];
  logic cap_busy[CAPN];
  logic cap_stb [CAPN];
  logic cap_rdy [CAPN];
  int   cap_n;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Queue one frame image {stop, data, start}, bit 0 sent first.
  task automatic push_frame(input logic [9:0] img);
    for (int k = 0; k < 10; k++) exp_q.push_back(img[k]);
  endtask

  // ---------------- driver tasks ----------------
  // Presents d and returns #1 after the transfer edge with s_valid still high.
  task automatic start_xfer(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    s_data  = d;
    s_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (s_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      s_valid = 1'b0;
      check("xfer_timeout", 0, 1);
    end
  endtask

  // Samples n cycles starting at the transfer edge (index 0).
  task automatic capture(input int n, input logic [7:0] late, input int drop_at,
                         input int flip_at);
    for (int e = 0; e < n; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
      end
      cap_fsk[e]  = fsk;
      cap_busy[e] = busy;
      cap_stb[e]  = stb;
      cap_rdy[e]  = s_ready;
      if (e == 0)       s_data  = late;
      if (e == flip_at) s_data  = ~late;
      if (e == drop_at) s_valid = 1'b0;
    end
    cap_n = n;
  endtask

  // Checks nf back-to-back frames in the capture against exp_q.
  task automatic check_frames(input int nf, input string tag);
    int end_e;
    int highs;
    int first_low;
    int scnt;
    int smis;
    int tog[300];
    int ntog;
    int errs;
    int ones;
    end_e     = nf * FRAME;
    highs     = 0;
    first_low = -1;
    scnt      = 0;
    smis      = 0;
    ntog      = 0;
    errs      = 0;
    ones      = 0;
    for (int e = 0; e < cap_n; e++) begin
      if (cap_busy[e]) highs++;
      else if (first_low < 0) first_low = e;
      if (cap_stb[e]) begin
        scnt++;
        if ((e % BITC) != 0 || e == 0 || e > end_e) smis++;
      end
    end
    check({tag, "_busy_len"}, highs, end_e);
    check({tag, "_busy_end"}, first_low, end_e);
    check({tag, "_strobe_cnt"}, scnt, nf * 10);
    check({tag, "_strobe_pos"}, smis, 0);

    for (int e = 1; e < end_e; e++) begin
      if (cap_fsk[e] != cap_fsk[e-1] && ntog < 300) begin
        tog[ntog] = e;
        ntog++;
      end
    end
    check({tag, "_first_rise"}, (ntog > 0) ? tog[0] : -1, 4);

    // An interval takes the tone of the bit in force at the toggle that starts it.
    for (int i = 0; i + 1 < ntog; i++) begin
      int len;
      int slot;
      len  = tog[i+1] - tog[i];
      slot = (tog[i] - 1) / BITC;
      if (len != (exp_q[slot] ? 3 : 4)) errs++;
    end
    check({tag, "_tone_intervals"}, errs, 0);

    // Decode each bit from the first full interval started inside its slot.
    for (int f = 0; f < nf; f++) begin
      int dec;
      int exp_img;
      dec     = 0;
      exp_img = 0;
      for (int k = 0; k < 10; k++) begin
        int  g;
        bit  found;
        g     = f * 10 + k;
        found = 1'b0;
        if (exp_q[g]) exp_img |= (1 << k);
        for (int i = 0; i + 1 < ntog && !found; i++) begin
          if ((tog[i] - 1) / BITC == g) begin
            found = 1'b1;
            if (tog[i+1] - tog[i] == 3) dec |= (1 << k);
            else if (tog[i+1] - tog[i] != 4) dec |= (1 << 10);
          end
        end
        if (!found) dec |= (1 << 11);
      end
      check($sformatf("%s_frame%0d_bits", tag, f), dec, exp_img);
    end

    for (int e = end_e; e < cap_n; e++) if (cap_fsk[e]) ones++;
    check({tag, "_idle_quiet"}, ones, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic [7:0] late;
    logic [9:0] img;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt;

    vecs[0] = '{data: 8'h3C, late: 8'h00, img: 10'h278};
    vecs[1] = '{data: 8'hA5, late: 8'h5A, img: 10'h34A};
    vecs[2] = '{data: 8'h01, late: 8'hFF, img: 10'h202};
    vecs[3] = '{data: 8'hFE, late: 8'h01, img: 10'h3FC};
    vecs[4] = '{data: 8'h5A, late: 8'hA5, img: 10'h2B4};

    rst_n   = 1'b0;
    enable  = 1'b0;
    s_data  = 8'h00;
    s_valid = 1'b0;
    en1     = 1'b0;
    data1   = 8'h00;
    valid1  = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_fsk", fsk, 0);
    check("rst_busy", busy, 0);
    check("rst_strobe", stb, 0);
    check("rst_ready", s_ready, 0);
    check("rst_state", st, 0);
    @(negedge clk);
    enable = 1'b1;
    check("rst_ready_low_in_reset", s_ready, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", s_ready, 1);

    // ---- abort at DATA bit 3, cycle 10 ----
    start_xfer(8'h96, ok);
    s_valid = 1'b0;
    if (ok) begin
      for (int e = 1; e <= 4 * BITC + 10; e++) begin
        @(posedge clk);
        #1;
      end
      check("abort_busy_before", busy, 1);
      check("abort_state_before", st, 2);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("abort_fsk", fsk, 0);
      check("abort_busy", busy, 0);
      check("abort_strobe", stb, 0);
      check("abort_ready", s_ready, 0);
      check("abort_state", st, 0);
      repeat (5) @(posedge clk);
      #1;
      cnt = 0;
      if (fsk) cnt++;
      if (busy) cnt++;
      check("abort_stays_idle", cnt, 0);
      @(negedge clk);
      enable = 1'b1;
      #1;
      check("ready_after_reenable", s_ready, 1);
    end

    // ---- table-driven frames ----
    foreach (vecs[i]) begin
      exp_q.delete();
      push_frame(vecs[i].img);
      start_xfer(vecs[i].data, ok);
      if (ok) begin
        capture(FRAME + 8, vecs[i].late, 0, 120);
        check_frames(1, $sformatf("v%0d", i));
      end
    end

    // ---- back-to-back: 0x00 then 0xFF with s_valid held ----
    exp_q.delete();
    push_frame(10'h200);
    push_frame(10'h3FE);
    start_xfer(8'h00, ok);
    if (ok) begin
      capture(2 * FRAME + 8, 8'hFF, FRAME, -1);
      cnt = 0;
      for (int e = 0; e < 2 * FRAME - 1; e++) if (cap_rdy[e]) cnt++;
      check("b2b_ready_cnt", cnt, 1);
      check("b2b_ready_last_stop", cap_rdy[FRAME-1], 1);
      check_frames(2, "b2b");
    end

    // ---- s_valid with enable low: no transfer ----
    @(negedge clk);
    enable  = 1'b0;
    s_data  = 8'h77;
    s_valid = 1'b1;
    #1;
    check("dis_ready", s_ready, 0);
    cnt = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (busy || st != 2'd0 || fsk) cnt++;
    end
    check("dis_no_xfer", cnt, 0);
    s_valid = 1'b0;
    enable  = 1'b1;

    // ---- async reset mid-toggle ----
    start_xfer(8'hA5, ok);
    s_valid = 1'b0;
    if (ok) begin
      cnt = 0;
      for (int i = 0; i < 20 && !fsk; i++) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      check("mid_rst_fsk_high_before", fsk, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_fsk", fsk, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", s_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid_rst_ready_release", s_ready, 1);
      cnt = 0;
      for (int e = 0; e < 12; e++) begin
        @(posedge clk);
        #1;
        if (fsk) cnt++;
      end
      check("mid_rst_fsk_quiet", cnt, 0);
    end

    // ---- idle mark tone, then a 0x00 frame ----
    begin
      int  last;
      int  idle_err;
      int  any_err;
      int  min_len;
      int  ntog;
      int  bcnt;
      logic prev;
      @(negedge clk);
      en1      = 1'b1;
      last     = -1;
      idle_err = 0;
      any_err  = 0;
      min_len  = 1000;
      ntog     = 0;
      bcnt     = 0;
      prev     = fsk1;
      for (int e = 0; e < 320; e++) begin
        @(posedge clk);
        #1;
        if (fsk1 != prev) begin
          if (last >= 0) begin
            if (e - last < min_len) min_len = e - last;
            if (e <= 40 && e - last != 3) idle_err++;
            if (e - last < 3 || e - last > 4) any_err++;
          end
          if (e <= 40) ntog++;
          last = e;
        end
        prev = fsk1;
        if (busy1) bcnt++;
        if (e == 39) begin
          check("mk_ready_idle", rdy1, 1);
          data1  = 8'h00;
          valid1 = 1'b1;
        end
        if (e == 40) begin
          valid1 = 1'b0;
          data1  = 8'hFF;
        end
      end
      check("mk_idle_period", idle_err, 0);
      check("mk_idle_running", (ntog >= 12) ? 1 : 0, 1);
      check("mk_intervals", any_err, 0);
      check("mk_min_interval", min_len, 3);
      check("mk_busy_len", bcnt, FRAME);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
